paddle_ai: RTL and testbench
============================

Name: paddle_ai

Overview:
- Computer opponent that drives one paddle's up/down button inputs in place of a human player.
- Watches the ball position and direction, waits a human-like reaction delay, then tracks the ball's y.
- When the ball moves away, it returns the paddle to screen centre.
- btn_up/btn_down connect to the paddle controller's button pair for that side; y_paddle feeds back from the controller's y output.

Parameters:
- V_ACTIVE, 480, visible lines.
- PADDLE_HALF, 30, half paddle height; target y is clamped to [PADDLE_HALF, V_ACTIVE-PADDLE_HALF].
- DEADBAND, 4, pixel tolerance around target; no move is commanded inside it.
- REACT_MS, 120, clk_1ms cycles spent in REACT before tracking; 0 skips REACT. Range 0..255.
- SIDE, 1, 1 = right paddle (ball approaches when ball_dx_pos=1); 0 = left paddle (ball approaches when ball_dx_pos=0).

Ports:
- clk_1ms, input, 1, 1 kHz game tick; all state updates on its rising edge.
- reset, input, 1, asynchronous, active-low reset (0 = reset).
- enable, input, 1, 1 = AI owns the paddle; 0 = idle, outputs low.
- switch, input, 1, pause; freezes state and counter and forces outputs low.
- y_ball, input, 10, ball centre y.
- ball_dx_pos, input, 1, 1 = ball moving toward +x.
- y_paddle, input, 10, current paddle centre y (feedback).
- btn_up, output, 1, request paddle y-1 this tick.
- btn_down, output, 1, request paddle y+1 this tick.
- ai_state, output, 2, current state: IDLE=0, CENTER=1, REACT=2, TRACK=3.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE, react counter=0, btn_up=0, btn_down=0.
  - Release is sampled on the next clk_1ms edge.
- approaching = (ball_dx_pos == SIDE).
- State transitions, evaluated each edge when switch=0, in priority order:
  - enable=0 -> IDLE from any state.
  - IDLE: enable=1 -> CENTER.
  - CENTER, approaching:
    - REACT_MS>0 -> REACT, counter loaded with REACT_MS-1.
    - REACT_MS=0 -> TRACK directly.
  - CENTER, not approaching -> stay in CENTER.
  - REACT, not approaching -> CENTER.
  - REACT, counter=0 -> TRACK.
  - REACT, otherwise -> decrement counter.
  - Result: the block spends exactly REACT_MS cycles in REACT.
  - TRACK, not approaching -> CENTER; otherwise stay.
- Pause: switch=1 holds state and counter unchanged; btn_up and btn_down are registered 0 on that edge.
- Target:
  - CENTER: target = V_ACTIVE/2.
  - TRACK: target = clamp(y_ball, PADDLE_HALF, V_ACTIVE-PADDLE_HALF).
  - IDLE, REACT: no target; outputs 0.
- Outputs are registered from the current (pre-edge) state and sampled inputs, giving one cycle of latency:
  - btn_down <= (target > y_paddle + DEADBAND).
  - btn_up <= (target + DEADBAND < y_paddle).
- Arithmetic: all comparisons use 11-bit unsigned zero-extended operands; no wrap.
- btn_up and btn_down are never 1 simultaneously.
- Target exactly at y_paddle ± DEADBAND gives no move.
- The clamp guarantees the AI never requests a move past the paddle controller's own edge stops.
- A direction flip in the same cycle as counter expiry goes to CENTER; direction has priority.
- Changing y_ball during REACT has no effect; only the y_ball value sampled in TRACK matters.
- Reset asserted mid-TRACK: outputs drop to 0 immediately (asynchronous); state returns to IDLE.

Test Plan:
- Reset held low, then released with enable=1, approaching=0, y_paddle=240 -> ai_state 0 then 1 next edge; btn_up=btn_down=0 throughout, since the paddle is at centre.
- CENTER, y_paddle=300 -> btn_up=1 from the following edge. Drive y_paddle down to 244 -> btn_up=0 (inside DEADBAND); at y_paddle=245 -> btn_up=1.
- Ball flips to approaching at edge N with REACT_MS=120 -> ai_state=2 for edges N..N+119 with outputs 0; ai_state=3 at edge N+120. With y_ball=400, y_paddle=240 -> btn_down=1 one edge later.
- TRACK, y_ball=5, y_paddle=40 -> target clamps to 30; btn_up=1 until y_paddle=34, then 0. y_ball=479 -> target clamps to 450.
- switch=1 during REACT at counter=50 for 20 cycles -> counter still 50 and ai_state still 2 afterwards; outputs 0. Same pause in TRACK -> outputs forced 0, resume the cycle after release.
- Direction reverses in REACT at counter=0 -> CENTER, not TRACK. enable=0 in TRACK -> IDLE next edge, outputs 0. Reset asserted mid-TRACK -> outputs 0 asynchronously.

Source files
------------

// File: rtl/paddle_ai.sv
// Computer-controlled paddle: after a reaction delay it steers the paddle
// toward the ball's y, and parks it at screen centre while the ball recedes.
module paddle_ai #(
  parameter int unsigned V_ACTIVE    = 480,
  parameter int unsigned PADDLE_HALF = 30,
  parameter int unsigned DEADBAND    = 4,
  parameter int unsigned REACT_MS    = 120,
  parameter int unsigned SIDE        = 1
) (
  input  logic       clk_1ms,
  input  logic       reset,
  input  logic       enable,
  input  logic       switch,
  input  logic [9:0] y_ball,
  input  logic       ball_dx_pos,
  input  logic [9:0] y_paddle,
  output logic       btn_up,
  output logic       btn_down,
  output logic [1:0] ai_state
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CENTER = 2'd1,
    REACT  = 2'd2,
    TRACK  = 2'd3
  } state_t;

  localparam logic [10:0] MID      = 11'(V_ACTIVE / 2);
  localparam logic [10:0] LO       = 11'(PADDLE_HALF);
  localparam logic [10:0] HI       = 11'(V_ACTIVE - PADDLE_HALF);
  localparam logic [10:0] DB       = 11'(DEADBAND);
  localparam logic [7:0]  REACT_LD = 8'((REACT_MS == 0) ? 0 : REACT_MS - 1);
  localparam logic        SIDE_BIT = 1'(SIDE);

  state_t      state, state_nx;
  logic [7:0]  cnt, cnt_nx;
  logic        approaching;
  logic        target_valid;
  logic [10:0] target, yb, yp;
  logic        up_nx, down_nx;

  assign approaching = (ball_dx_pos == SIDE_BIT);
  assign yb          = {1'b0, y_ball};
  assign yp          = {1'b0, y_paddle};
  assign ai_state    = state;

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    if (!switch) begin
      if (!enable) begin
        state_nx = IDLE;
      end else begin
        unique case (state)
          IDLE:   state_nx = CENTER;
          CENTER: begin
            if (approaching) begin
              if (REACT_MS > 0) begin
                state_nx = REACT;
                cnt_nx   = REACT_LD;
              end else begin
                state_nx = TRACK;
              end
            end
          end
          // Direction reversal outranks counter expiry.
          REACT: begin
            if (!approaching)    state_nx = CENTER;
            else if (cnt == '0)  state_nx = TRACK;
            else                 cnt_nx   = cnt - 8'd1;
          end
          TRACK:  if (!approaching) state_nx = CENTER;
          default: state_nx = IDLE;
        endcase
      end
    end
  end

  always_comb begin
    target_valid = 1'b0;
    target       = MID;
    unique case (state)
      CENTER: begin
        target_valid = 1'b1;
        target       = MID;
      end
      TRACK: begin
        target_valid = 1'b1;
        if (yb < LO)      target = LO;
        else if (yb > HI) target = HI;
        else              target = yb;
      end
      default: target_valid = 1'b0;
    endcase
  end

  assign down_nx = !switch && enable && target_valid && (target > yp + DB);
  assign up_nx   = !switch && enable && target_valid && (target + DB < yp);

  always_ff @(posedge clk_1ms or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      cnt      <= '0;
      btn_up   <= 1'b0;
      btn_down <= 1'b0;
    end else begin
      state    <= state_nx;
      cnt      <= cnt_nx;
      btn_up   <= up_nx;
      btn_down <= down_nx;
    end
  end

endmodule

// File: tb/tb_paddle_ai.sv
// Directed self-checking bench for paddle_ai with default parameters.
module tb_paddle_ai;

  logic       clk_1ms;
  logic       reset;
  logic       enable;
  logic       switch;
  logic [9:0] y_ball;
  logic       ball_dx_pos;
  logic [9:0] y_paddle;
  logic       btn_up;
  logic       btn_down;
  logic [1:0] ai_state;

  int checks = 0;
  int errors = 0;

  paddle_ai #(
    .V_ACTIVE(480),
    .PADDLE_HALF(30),
    .DEADBAND(4),
    .REACT_MS(120),
    .SIDE(1)
  ) dut (
    .clk_1ms(clk_1ms),
    .reset(reset),
    .enable(enable),
    .switch(switch),
    .y_ball(y_ball),
    .ball_dx_pos(ball_dx_pos),
    .y_paddle(y_paddle),
    .btn_up(btn_up),
    .btn_down(btn_down),
    .ai_state(ai_state)
  );

  initial clk_1ms = 1'b0;
  always #5 clk_1ms = ~clk_1ms;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk_1ms);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic test_reset();
    reset = 1'b0; enable = 1'b1; switch = 1'b0;
    ball_dx_pos = 1'b0; y_paddle = 10'd240; y_ball = 10'd240;
    ticks(3);
    checks++;
    if (ai_state !== 2'd0 || btn_up !== 1'b0 || btn_down !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: state=%0d up=%b down=%b, want 0 0 0", ai_state, btn_up, btn_down);
    end
    reset = 1'b1;
    tick();
    checks++;
    if (ai_state !== 2'd1 || btn_up !== 1'b0 || btn_down !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: state=%0d up=%b down=%b, want 1 0 0", ai_state, btn_up, btn_down);
    end
    tick();
    checks++;
    if (ai_state !== 2'd1 || btn_up !== 1'b0 || btn_down !== 1'b0) begin
      errors++;
      $display("FAIL center_at_mid: state=%0d up=%b down=%b, want 1 0 0", ai_state, btn_up, btn_down);
    end
  endtask

  task automatic test_center();
    y_paddle = 10'd300; tick();
    checks++;
    if (btn_up !== 1'b1 || btn_down !== 1'b0) begin
      errors++;
      $display("FAIL center_up_300: up=%b down=%b, want 1 0", btn_up, btn_down);
    end
    y_paddle = 10'd244; tick();
    checks++;
    if (btn_up !== 1'b0) begin
      errors++;
      $display("FAIL center_deadband_244: up=%b, want 0", btn_up);
    end
    y_paddle = 10'd245; tick();
    checks++;
    if (btn_up !== 1'b1) begin
      errors++;
      $display("FAIL center_edge_245: up=%b, want 1", btn_up);
    end
    y_paddle = 10'd236; tick();
    checks++;
    if (btn_down !== 1'b0 || btn_up !== 1'b0) begin
      errors++;
      $display("FAIL center_deadband_236: up=%b down=%b, want 0 0", btn_up, btn_down);
    end
    y_paddle = 10'd235; tick();
    checks++;
    if (btn_down !== 1'b1 || btn_up !== 1'b0) begin
      errors++;
      $display("FAIL center_down_235: up=%b down=%b, want 0 1", btn_up, btn_down);
    end
  endtask

  task automatic test_react();
    y_paddle = 10'd240; y_ball = 10'd400; ball_dx_pos = 1'b1;
    tick();
    for (int i = 0; i < 120; i++) begin
      checks++;
      if (ai_state !== 2'd2 || btn_up !== 1'b0 || btn_down !== 1'b0) begin
        errors++;
        $display("FAIL react_hold[%0d]: state=%0d up=%b down=%b, want 2 0 0", i, ai_state, btn_up, btn_down);
      end
      tick();
    end
    checks++;
    if (ai_state !== 2'd3 || btn_down !== 1'b0) begin
      errors++;
      $display("FAIL react_to_track: state=%0d down=%b, want 3 0", ai_state, btn_down);
    end
    tick();
    checks++;
    if (btn_down !== 1'b1 || btn_up !== 1'b0) begin
      errors++;
      $display("FAIL track_down: up=%b down=%b, want 0 1", btn_up, btn_down);
    end
  endtask

  task automatic test_clamp();
    y_ball = 10'd5; y_paddle = 10'd40; tick();
    checks++;
    if (btn_up !== 1'b1) begin
      errors++;
      $display("FAIL clamp_lo_40: up=%b, want 1", btn_up);
    end
    y_paddle = 10'd35; tick();
    checks++;
    if (btn_up !== 1'b1) begin
      errors++;
      $display("FAIL clamp_lo_35: up=%b, want 1", btn_up);
    end
    y_paddle = 10'd34; tick();
    checks++;
    if (btn_up !== 1'b0 || btn_down !== 1'b0) begin
      errors++;
      $display("FAIL clamp_lo_34: up=%b down=%b, want 0 0", btn_up, btn_down);
    end
    y_ball = 10'd479; y_paddle = 10'd445; tick();
    checks++;
    if (btn_down !== 1'b1) begin
      errors++;
      $display("FAIL clamp_hi_445: down=%b, want 1", btn_down);
    end
    y_paddle = 10'd446; tick();
    checks++;
    if (btn_down !== 1'b0 || btn_up !== 1'b0) begin
      errors++;
      $display("FAIL clamp_hi_446: up=%b down=%b, want 0 0", btn_up, btn_down);
    end
  endtask

  task automatic test_pause_react();
    ball_dx_pos = 1'b0; tick();
    ball_dx_pos = 1'b1; tick();
    ticks(69);
    switch = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      checks++;
      if (ai_state !== 2'd2 || btn_up !== 1'b0 || btn_down !== 1'b0) begin
        errors++;
        $display("FAIL pause_react[%0d]: state=%0d up=%b down=%b, want 2 0 0", i, ai_state, btn_up, btn_down);
      end
    end
    switch = 1'b0;
    ticks(50);
    checks++;
    if (ai_state !== 2'd2) begin
      errors++;
      $display("FAIL pause_react_count: state=%0d, want 2", ai_state);
    end
    tick();
    checks++;
    if (ai_state !== 2'd3) begin
      errors++;
      $display("FAIL pause_react_expire: state=%0d, want 3", ai_state);
    end
  endtask

  task automatic test_pause_track();
    y_ball = 10'd400; y_paddle = 10'd240; tick();
    checks++;
    if (btn_down !== 1'b1) begin
      errors++;
      $display("FAIL pause_track_pre: down=%b, want 1", btn_down);
    end
    switch = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (ai_state !== 2'd3 || btn_down !== 1'b0 || btn_up !== 1'b0) begin
        errors++;
        $display("FAIL pause_track[%0d]: state=%0d up=%b down=%b, want 3 0 0", i, ai_state, btn_up, btn_down);
      end
    end
    switch = 1'b0; tick();
    checks++;
    if (btn_down !== 1'b1) begin
      errors++;
      $display("FAIL pause_track_resume: down=%b, want 1", btn_down);
    end
  endtask

  task automatic test_flip_expiry();
    ball_dx_pos = 1'b0; tick();
    ball_dx_pos = 1'b1; tick();
    ticks(119);
    checks++;
    if (ai_state !== 2'd2) begin
      errors++;
      $display("FAIL flip_pre: state=%0d, want 2", ai_state);
    end
    ball_dx_pos = 1'b0; tick();
    checks++;
    if (ai_state !== 2'd1) begin
      errors++;
      $display("FAIL flip_at_expiry: state=%0d, want 1", ai_state);
    end
  endtask

  task automatic test_enable_off();
    y_ball = 10'd400; y_paddle = 10'd240;
    ball_dx_pos = 1'b1; tick();
    ticks(121);
    checks++;
    if (ai_state !== 2'd3 || btn_down !== 1'b1) begin
      errors++;
      $display("FAIL enable_pre: state=%0d down=%b, want 3 1", ai_state, btn_down);
    end
    enable = 1'b0; tick();
    checks++;
    if (ai_state !== 2'd0 || btn_down !== 1'b0 || btn_up !== 1'b0) begin
      errors++;
      $display("FAIL enable_off: state=%0d up=%b down=%b, want 0 0 0", ai_state, btn_up, btn_down);
    end
  endtask

  task automatic test_async_reset();
    enable = 1'b1; ball_dx_pos = 1'b0; tick();
    ball_dx_pos = 1'b1; tick();
    ticks(121);
    checks++;
    if (ai_state !== 2'd3 || btn_down !== 1'b1) begin
      errors++;
      $display("FAIL areset_pre: state=%0d down=%b, want 3 1", ai_state, btn_down);
    end
    #2 reset = 1'b0;
    #1;
    checks++;
    if (ai_state !== 2'd0 || btn_down !== 1'b0 || btn_up !== 1'b0) begin
      errors++;
      $display("FAIL areset_async: state=%0d up=%b down=%b, want 0 0 0", ai_state, btn_up, btn_down);
    end
    tick();
    checks++;
    if (ai_state !== 2'd0 || btn_down !== 1'b0) begin
      errors++;
      $display("FAIL areset_hold: state=%0d down=%b, want 0 0", ai_state, btn_down);
    end
    reset = 1'b1; tick();
    checks++;
    if (ai_state !== 2'd1) begin
      errors++;
      $display("FAIL areset_release: state=%0d, want 1", ai_state);
    end
  endtask

  initial begin
    test_reset();
    test_center();
    test_react();
    test_clamp();
    test_pause_react();
    test_pause_track();
    test_flip_expiry();
    test_enable_off();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
